// File: rtl/wb_bus_arbiter.sv
// Wishbone classic arbiter: NUM_MASTERS masters share one slave port through a
// registered one-hot grant, with fixed-priority or round-robin selection and a strobe watchdog.
module wb_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DW          = 16,
  parameter int AW          = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
  output logic [DW-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_stall_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  input  logic [DW-1:0]                 s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  output logic [NUM_MASTERS-1:0]        gnt_o
);

  localparam int SW = DW / 8;
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANTED, TIMEOUT_ERR} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] gnt_nxt;
  logic [LW-1:0]          last_gnt, last_gnt_nxt;
  logic [LW-1:0]          gnt_idx, win_idx;
  logic                   gnt_cyc;
  logic                   wd_tick;
  logic [CW-1:0]          wd_cnt, wd_cnt_nxt;

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt_o[k]) gnt_idx = LW'(k);
    end
  end

  // Scan downwards so the last hit is the closest requester after last_gnt.
  always_comb begin
    win_idx = '0;
    if (ROUND_ROBIN != 0) begin
      for (int i = NUM_MASTERS; i >= 1; i--) begin
        if (m_cyc_i[(int'(last_gnt) + i) % NUM_MASTERS])
          win_idx = LW'((int'(last_gnt) + i) % NUM_MASTERS);
      end
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (m_cyc_i[i]) win_idx = LW'(i);
      end
    end
  end

  assign gnt_cyc = |(gnt_o & m_cyc_i);
  assign wd_tick = (state == GRANTED) && s_stb_o && !s_ack_i && !s_err_i;

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_o;
    last_gnt_nxt = last_gnt;
    wd_cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          state_nxt        = GRANTED;
          gnt_nxt          = '0;
          gnt_nxt[win_idx] = 1'b1;
        end
      end
      GRANTED: begin
        if (!gnt_cyc) begin
          state_nxt    = IDLE;
          gnt_nxt      = '0;
          last_gnt_nxt = gnt_idx;
        end else if (TIMEOUT > 0 && wd_tick) begin
          wd_cnt_nxt = wd_cnt + CW'(1);
          if (wd_cnt_nxt == CW'(TIMEOUT)) begin
            state_nxt  = TIMEOUT_ERR;
            wd_cnt_nxt = '0;
          end
        end
      end
      TIMEOUT_ERR: begin
        if (gnt_cyc) begin
          state_nxt = GRANTED;
        end else begin
          state_nxt    = IDLE;
          gnt_nxt      = '0;
          last_gnt_nxt = gnt_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      gnt_o    <= '0;
      last_gnt <= LW'(NUM_MASTERS - 1);
      wd_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      gnt_o    <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      wd_cnt   <= wd_cnt_nxt;
    end
  end

  // Slave side follows the owner combinationally; bus controls are only live in GRANTED.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt_o[k]) begin
        s_cyc_o = m_cyc_i[k];
        s_stb_o = m_cyc_i[k] & m_stb_i[k];
        s_we_o  = m_we_i[k];
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
        s_sel_o = m_sel_i[k*SW +: SW];
      end
    end
    if (state != GRANTED) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (state == GRANTED) begin
      m_ack_o = gnt_o & {NUM_MASTERS{s_ack_i}};
      m_err_o = gnt_o & {NUM_MASTERS{s_err_i}};
    end else if (state == TIMEOUT_ERR) begin
      m_err_o = gnt_o;
    end
  end

  assign m_stall_o = m_cyc_i & ~gnt_o;
  assign m_dat_o   = rst_i ? '0 : s_dat_i;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: a 4-master round-robin instance (TIMEOUT=4) and a
// 2-master fixed-priority instance (TIMEOUT=1), with grant/ack/err scoreboards.
module tb_wb_bus_arbiter;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Round-robin instance
  logic [3:0]   rr_cyc, rr_stb, rr_we;
  logic [127:0] rr_adr;
  logic [63:0]  rr_wdat;
  logic [7:0]   rr_sel;
  logic [15:0]  rr_m_dat;
  logic [3:0]   rr_ack, rr_err, rr_stall, rr_gnt;
  logic         rr_s_cyc, rr_s_stb, rr_s_we;
  logic [31:0]  rr_s_adr;
  logic [15:0]  rr_s_dat;
  logic [1:0]   rr_s_sel;
  logic [15:0]  rr_s_dat_i;
  logic         rr_s_ack, rr_s_err;

  wb_bus_arbiter #(.NUM_MASTERS(4), .DW(16), .AW(32), .ROUND_ROBIN(1), .TIMEOUT(4)) u_rr (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(rr_cyc), .m_stb_i(rr_stb), .m_we_i(rr_we),
    .m_adr_i(rr_adr), .m_dat_i(rr_wdat), .m_sel_i(rr_sel),
    .m_dat_o(rr_m_dat), .m_ack_o(rr_ack), .m_err_o(rr_err), .m_stall_o(rr_stall),
    .s_cyc_o(rr_s_cyc), .s_stb_o(rr_s_stb), .s_we_o(rr_s_we),
    .s_adr_o(rr_s_adr), .s_dat_o(rr_s_dat), .s_sel_o(rr_s_sel),
    .s_dat_i(rr_s_dat_i), .s_ack_i(rr_s_ack), .s_err_i(rr_s_err),
    .gnt_o(rr_gnt)
  );

  // Fixed-priority instance
  logic [1:0]  fp_cyc, fp_stb, fp_we;
  logic [63:0] fp_adr;
  logic [31:0] fp_wdat;
  logic [3:0]  fp_sel;
  logic [15:0] fp_m_dat;
  logic [1:0]  fp_ack, fp_err, fp_stall, fp_gnt;
  logic        fp_s_cyc, fp_s_stb, fp_s_we;
  logic [31:0] fp_s_adr;
  logic [15:0] fp_s_dat;
  logic [1:0]  fp_s_sel;
  logic [15:0] fp_s_dat_i;
  logic        fp_s_ack, fp_s_err;

  wb_bus_arbiter #(.NUM_MASTERS(2), .DW(16), .AW(32), .ROUND_ROBIN(0), .TIMEOUT(1)) u_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(fp_cyc), .m_stb_i(fp_stb), .m_we_i(fp_we),
    .m_adr_i(fp_adr), .m_dat_i(fp_wdat), .m_sel_i(fp_sel),
    .m_dat_o(fp_m_dat), .m_ack_o(fp_ack), .m_err_o(fp_err), .m_stall_o(fp_stall),
    .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_we_o(fp_s_we),
    .s_adr_o(fp_s_adr), .s_dat_o(fp_s_dat), .s_sel_o(fp_s_sel),
    .s_dat_i(fp_s_dat_i), .s_ack_i(fp_s_ack), .s_err_i(fp_s_err),
    .gnt_o(fp_gnt)
  );

  logic [3:0]  rr_gnt_q[$];
  logic [19:0] rr_ack_q[$];
  logic [3:0]  rr_err_q[$];
  logic [1:0]  fp_gnt_q[$];
  logic [1:0]  fp_err_q[$];
  logic [3:0]  rr_gnt_prev = '0;
  logic [1:0]  fp_gnt_prev = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_rr_gnt(output logic [3:0] g);
    int n = 0;
    @(negedge clk_i);
    while (rr_gnt == 4'd0 && n < 20) begin
      tick();
      @(negedge clk_i);
      n++;
    end
    check_eq("rr_gnt_wait", {31'd0, rr_gnt != 4'd0}, 32'd1);
    g = rr_gnt;
  endtask

  task automatic rr_route_chk(input int k);
    check_eq("rr_s_adr", rr_s_adr, rr_adr[k*32 +: 32]);
    check_eq("rr_s_dat", {16'd0, rr_s_dat}, {16'd0, rr_wdat[k*16 +: 16]});
    check_eq("rr_s_sel", {30'd0, rr_s_sel}, {30'd0, rr_sel[k*2 +: 2]});
    check_eq("rr_s_we", {31'd0, rr_s_we}, {31'd0, rr_we[k]});
  endtask

  // Scoreboard monitors: every new grant, every ack and every err pops one expectation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rr_gnt != 4'd0 && rr_gnt_prev == 4'd0) begin
        if (rr_gnt_q.size() == 0) check_eq("rr_gnt_unexpected", rr_gnt, 32'd0);
        else                      check_eq("rr_gnt_order", rr_gnt, rr_gnt_q.pop_front());
      end
      if (rr_ack != 4'd0) begin
        if (rr_ack_q.size() == 0) check_eq("rr_ack_unexpected", rr_ack, 32'd0);
        else                      check_eq("rr_ack_route", {rr_ack, rr_m_dat}, rr_ack_q.pop_front());
      end
      if (rr_err != 4'd0) begin
        if (rr_err_q.size() == 0) check_eq("rr_err_unexpected", rr_err, 32'd0);
        else                      check_eq("rr_err_route", rr_err, rr_err_q.pop_front());
      end
      if (fp_gnt != 2'd0 && fp_gnt_prev == 2'd0) begin
        if (fp_gnt_q.size() == 0) check_eq("fp_gnt_unexpected", fp_gnt, 32'd0);
        else                      check_eq("fp_gnt_order", fp_gnt, fp_gnt_q.pop_front());
      end
      if (fp_err != 2'd0) begin
        if (fp_err_q.size() == 0) check_eq("fp_err_unexpected", fp_err, 32'd0);
        else                      check_eq("fp_err_route", fp_err, fp_err_q.pop_front());
      end
    end
    rr_gnt_prev = rr_gnt;
    fp_gnt_prev = fp_gnt;
  end

  initial begin
    #500000;
    $display("FAIL tb_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    rst_i = 1'b1;
    rr_cyc = '0; rr_stb = '0; rr_we = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      rr_adr[k*32 +: 32]  = 32'h4000_0000 + 32'(k * 16);
      rr_wdat[k*16 +: 16] = 16'h5A00 + 16'(k);
      rr_sel[k*2 +: 2]    = 2'(k + 1);
    end
    rr_s_dat_i = 16'h1234; rr_s_ack = 1'b1; rr_s_err = 1'b1;
    fp_cyc = '0; fp_stb = '0; fp_we = 2'b01;
    fp_adr = {32'h0000_2222, 32'h0000_1111};
    fp_wdat = {16'hB222, 16'hA111};
    fp_sel = 4'b1001;
    fp_s_dat_i = '0; fp_s_ack = 1'b0; fp_s_err = 1'b0;

    // Reset state, with a slave shouting ack/err and data
    tick();
    check_eq("rst_gnt", rr_gnt, 32'd0);
    check_eq("rst_s_cyc", {31'd0, rr_s_cyc}, 32'd0);
    check_eq("rst_s_adr", rr_s_adr, 32'd0);
    check_eq("rst_ack", rr_ack, 32'd0);
    check_eq("rst_err", rr_err, 32'd0);
    check_eq("rst_m_dat", rr_m_dat, 32'd0);
    check_eq("rst_fp_gnt", fp_gnt, 32'd0);
    tick();
    rst_i = 1'b0; rr_s_ack = 1'b0; rr_s_err = 1'b0;

    // Fixed priority, both request together; TIMEOUT=1 error on first unacked strobe
    tick();
    fp_cyc = 2'b11;
    fp_gnt_q.push_back(2'b01);
    fp_gnt_q.push_back(2'b10);
    @(negedge clk_i);
    check_eq("fp_latency", fp_gnt, 32'd0);
    check_eq("fp_stall_req", fp_stall, 32'h3);
    tick();
    @(negedge clk_i);
    check_eq("fp_adr0", fp_s_adr, 32'h0000_1111);
    check_eq("fp_s_cyc", {31'd0, fp_s_cyc}, 32'd1);
    check_eq("fp_stall_g0", fp_stall, 32'h2);
    tick(); tick();
    @(negedge clk_i);
    check_eq("fp_hold", fp_stall, 32'h2);
    tick();
    fp_cyc = 2'b10;
    tick();
    @(negedge clk_i);
    check_eq("fp_gap", fp_gnt, 32'd0);
    tick();
    @(negedge clk_i);
    check_eq("fp_adr1", fp_s_adr, 32'h0000_2222);
    check_eq("fp_stall_g1", fp_stall, 32'd0);
    tick();
    fp_stb = 2'b10;
    @(negedge clk_i);
    check_eq("fp_stb_on", {31'd0, fp_s_stb}, 32'd1);
    tick();
    fp_err_q.push_back(2'b10);
    @(negedge clk_i);
    check_eq("fp_to_stb", {31'd0, fp_s_stb}, 32'd0);
    tick();
    fp_cyc = '0; fp_stb = '0;
    tick(); tick();

    // Round robin, all four masters requesting, single-beat transfers
    rr_cyc = 4'hF; rr_stb = 4'hF;
    rr_gnt_q.push_back(4'b0001); rr_gnt_q.push_back(4'b0010);
    rr_gnt_q.push_back(4'b0100); rr_gnt_q.push_back(4'b1000);
    rr_gnt_q.push_back(4'b0001);
    for (int t = 0; t < 5; t++) begin
      logic [15:0] d;
      wait_rr_gnt(g);
      rr_route_chk(t % 4);
      if (t == 0) check_eq("rr_stall", rr_stall, 32'hE);
      tick();
      d = 16'h1000 + 16'(t);
      rr_s_ack = 1'b1; rr_s_dat_i = d;
      rr_ack_q.push_back({g, d});
      tick();
      rr_s_ack = 1'b0; rr_cyc &= ~g; rr_stb &= ~g;
      tick();
      if (t < 4) begin
        rr_cyc |= g; rr_stb |= g;
      end
      @(negedge clk_i);
      check_eq("rr_idle_gap", rr_gnt, 32'd0);
    end
    rr_cyc = '0; rr_stb = '0;
    tick();

    // Locked cycle: master 1 runs three beats while master 0 waits
    rr_cyc = 4'b0010; rr_stb = 4'b0010;
    rr_gnt_q.push_back(4'b0010);
    rr_gnt_q.push_back(4'b0001);
    tick();
    rr_cyc = 4'b0011; rr_stb = 4'b0011;
    wait_rr_gnt(g);
    check_eq("lock_stall", rr_stall, 32'h1);
    for (int b = 0; b < 3; b++) begin
      tick();
      rr_s_ack = 1'b1; rr_s_dat_i = 16'hA000 + 16'(b);
      rr_ack_q.push_back({4'b0010, 16'hA000 + 16'(b)});
      @(negedge clk_i);
      check_eq("lock_hold", rr_gnt, 32'h2);
    end
    tick();
    rr_s_ack = 1'b0; rr_cyc = 4'b0001; rr_stb = 4'b0001;
    tick();
    @(negedge clk_i);
    check_eq("lock_gap", rr_gnt, 32'd0);
    check_eq("lock_gap_stall", rr_stall, 32'h1);
    wait_rr_gnt(g);
    rr_route_chk(0);
    tick();
    rr_cyc = '0; rr_stb = '0;
    tick(); tick();

    // Watchdog: slave never acks master 2
    rr_cyc = 4'b0100; rr_stb = 4'b0100;
    rr_gnt_q.push_back(4'b0100);
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk_i);
      check_eq("to_stb_on", {31'd0, rr_s_stb}, 32'd1);
    end
    tick();
    rr_err_q.push_back(4'b0100);
    rr_s_ack = 1'b1;
    @(negedge clk_i);
    check_eq("to_stb_low", {31'd0, rr_s_stb}, 32'd0);
    check_eq("to_cyc_low", {31'd0, rr_s_cyc}, 32'd0);
    tick();
    rr_s_ack = 1'b0;
    @(negedge clk_i);
    check_eq("to_resume_gnt", rr_gnt, 32'h4);
    check_eq("to_resume_stb", {31'd0, rr_s_stb}, 32'd1);
    tick();
    rr_cyc = '0; rr_stb = '0;
    tick();
    rr_s_ack = 1'b1;
    tick();
    rr_s_ack = 1'b0;
    tick();

    // Response routing to master 2, including simultaneous ack+err
    rr_cyc = 4'b0100; rr_stb = 4'b0100;
    rr_gnt_q.push_back(4'b0100);
    wait_rr_gnt(g);
    rr_route_chk(2);
    tick();
    rr_s_ack = 1'b1; rr_s_dat_i = 16'hBEEF;
    rr_ack_q.push_back({4'b0100, 16'hBEEF});
    @(negedge clk_i);
    check_eq("route_m_dat", rr_m_dat, 32'hBEEF);
    tick();
    rr_s_ack = 1'b0; rr_s_err = 1'b1;
    rr_err_q.push_back(4'b0100);
    tick();
    rr_s_ack = 1'b1; rr_s_dat_i = 16'h0F0F;
    rr_ack_q.push_back({4'b0100, 16'h0F0F});
    rr_err_q.push_back(4'b0100);
    tick();
    rr_s_ack = 1'b0; rr_s_err = 1'b0; rr_cyc = '0; rr_stb = '0;
    tick(); tick();

    // Asynchronous reset in the middle of master 3's transfer
    rr_cyc = 4'b1000; rr_stb = 4'b1000;
    rr_gnt_q.push_back(4'b1000);
    wait_rr_gnt(g);
    tick();
    rr_cyc = 4'b1001; rr_stb = 4'b1001; rr_s_ack = 1'b1; rr_s_dat_i = 16'hC0DE;
    #1;
    check_eq("pre_rst_cyc", {31'd0, rr_s_cyc}, 32'd1);
    check_eq("pre_rst_ack", rr_ack, 32'h8);
    rst_i = 1'b1;
    #1;
    check_eq("arst_s_cyc", {31'd0, rr_s_cyc}, 32'd0);
    check_eq("arst_gnt", rr_gnt, 32'd0);
    check_eq("arst_ack", rr_ack, 32'd0);
    check_eq("arst_stall", rr_stall, 32'h9);
    tick(); tick();
    rr_gnt_q.push_back(4'b0001);
    rst_i = 1'b0; rr_s_ack = 1'b0;
    wait_rr_gnt(g);
    check_eq("post_rst_stall", rr_stall, 32'h8);
    tick();
    rr_cyc = '0; rr_stb = '0;
    tick(); tick();

    check_eq("rr_gnt_q_left", rr_gnt_q.size(), 32'd0);
    check_eq("rr_ack_q_left", rr_ack_q.size(), 32'd0);
    check_eq("rr_err_q_left", rr_err_q.size(), 32'd0);
    check_eq("fp_gnt_q_left", fp_gnt_q.size(), 32'd0);
    check_eq("fp_err_q_left", fp_err_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
